img_decimator: RTL and testbench

Upstream stage of the feed-forward NN. Accepts a raster stream of 8-bit grayscale pixels (IN_W x IN_H) and box-filters it by DEC x DEC into a 16x16 = 256-byte input image. The image is held in a buffer whose combinational read port replaces the static input-layer ROM, addressed by the controller's cycle count. A frame_ready/frame_ack handshake gates when the NN may consume the image.

---
 rtl/img_decim_pkg.sv | 12 +
 rtl/decim_bank.sv | 26 ++
 rtl/img_decimator.sv | 162 ++++++++++++++++
 tb/tb_img_decimator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/img_decim_pkg.sv
// Shared types and default geometry for the image decimator.
package img_decim_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, FULL} state_t;

  localparam int DEC_SHIFT = 3;
  localparam int ACC_W     = 8 + 2*DEC_SHIFT;
  localparam int OUT_W_DEF = 16;
  localparam int OUT_H_DEF = 16;
  localparam int IMG_LEN   = OUT_W_DEF*OUT_H_DEF;

endpackage

// File: rtl/decim_bank.sv
// Image byte store: synchronous write, combinational read, 0 beyond the image.
module decim_bank
  import img_decim_pkg::*;
#(
  parameter int LEN   = IMG_LEN,
  parameter int ADR_W = 9
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [$clog2(LEN)-1:0] wa,
  input  logic [7:0]             wd,
  input  logic [ADR_W-1:0]       ra,
  output logic [7:0]             rd
);

  localparam int BW = $clog2(LEN);

  logic [7:0] mem [LEN];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = (int'(ra) < LEN) ? mem[ra[BW-1:0]] : 8'h00;

endmodule

// File: rtl/img_decimator.sv
// Box-filters a raster pixel stream by DEC x DEC into the NN input image.
// Define IMG_DECIMATOR_DOUBLE_BUF_EN for a ping-pong buffer that lets capture run ahead.
module img_decimator
  import img_decim_pkg::*;
#(
  parameter int IN_W  = 128,
  parameter int IN_H  = 128,
  parameter int DEC   = 1 << DEC_SHIFT,
  parameter int OUT_W = OUT_W_DEF,
  parameter int OUT_H = OUT_H_DEF,
  parameter int ADR_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic [7:0]       pix_data,
  output logic             pix_ready,
  input  logic [ADR_W-1:0] rd_adr,
  output logic [7:0]       rd_byte,
  output logic             frame_ready,
  input  logic             frame_ack,
  output logic             sync_err
);

  localparam int SH    = $clog2(DEC);
  // package width is for the default DEC; rescale when DEC is overridden
  localparam int ACC_L = ACC_W + 2*(SH - DEC_SHIFT);
  localparam int LEN   = OUT_W*OUT_H;
  localparam int BW    = $clog2(LEN);
  localparam int CW    = $clog2(IN_W);
  localparam int RW    = $clog2(IN_H);
  localparam int OW    = $clog2(OUT_W);

  function automatic logic [7:0] box_mean(input logic [ACC_L-1:0] sum);
    return 8'(sum >> (2*SH));
  endfunction

  state_t           state, state_nxt;
  logic             rdy_nxt;
  logic [CW-1:0]    col, ecol;
  logic [RW-1:0]    row, erow;
  logic [ACC_L-1:0] acc [OUT_W];
  logic [ACC_L-1:0] acc_sum;
  logic [OW-1:0]    ci;
  logic             xfer, proc, blk, last, we;
  logic [BW-1:0]    wa;
  logic [7:0]       wd;

  assign pix_ready = (state != FULL);
  assign xfer      = pix_valid & pix_ready;
  // in IDLE only a start-of-frame pixel is taken; a sof always restarts at (0,0)
  assign proc      = xfer & ((state == CAPTURE) | pix_sof);
  assign ecol      = pix_sof ? '0 : col;
  assign erow      = pix_sof ? '0 : row;
  assign ci        = OW'(ecol >> SH);
  assign blk       = (&ecol[SH-1:0]) & (&erow[SH-1:0]);
  assign last      = (ecol == CW'(IN_W-1)) & (erow == RW'(IN_H-1));
  assign acc_sum   = (pix_sof ? '0 : acc[ci]) + ACC_L'(pix_data);
  assign we        = proc & blk;
  assign wa        = BW'(int'(erow >> SH) * OUT_W + int'(ci));
  assign wd        = box_mean(acc_sum);

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      for (int i = 0; i < OUT_W; i++) acc[i] <= '0;
    end else if (proc) begin
      if (ecol == CW'(IN_W-1)) begin
        col <= '0;
        row <= last ? '0 : erow + 1'b1;
      end else begin
        col <= ecol + 1'b1;
        row <= erow;
      end
      for (int i = 0; i < OUT_W; i++) begin
        if (i == int'(ci))  acc[i] <= blk ? '0 : acc_sum;
        else if (pix_sof)   acc[i] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      frame_ready <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_ready <= rdy_nxt;
      sync_err    <= xfer & pix_sof & (state == CAPTURE);
    end
  end

`ifdef IMG_DECIMATOR_DOUBLE_BUF_EN
  logic       bank_sel, swap;
  logic [7:0] rd0, rd1;

  // frame_ready doubles as the valid flag of the presented bank; FULL means the capture bank waits
  always_comb begin
    state_nxt = state;
    rdy_nxt   = frame_ready;
    swap      = 1'b0;
    if (frame_ack) rdy_nxt = 1'b0;
    case (state)
      IDLE:    if (proc) state_nxt = CAPTURE;
      CAPTURE: if (proc && last) begin
                 if (!frame_ready || frame_ack) begin
                   swap      = 1'b1;
                   rdy_nxt   = 1'b1;
                   state_nxt = IDLE;
                 end else begin
                   state_nxt = FULL;
                 end
               end
      FULL:    if (frame_ack) begin
                 swap      = 1'b1;
                 rdy_nxt   = 1'b1;
                 state_nxt = IDLE;
               end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)     bank_sel <= 1'b0;
    else if (swap) bank_sel <= ~bank_sel;
  end

  decim_bank #(.LEN(LEN), .ADR_W(ADR_W)) u_bank0 (
    .clk(clk), .we(we & ~bank_sel), .wa(wa), .wd(wd), .ra(rd_adr), .rd(rd0)
  );
  decim_bank #(.LEN(LEN), .ADR_W(ADR_W)) u_bank1 (
    .clk(clk), .we(we & bank_sel), .wa(wa), .wd(wd), .ra(rd_adr), .rd(rd1)
  );

  assign rd_byte = bank_sel ? rd0 : rd1;
`else
  always_comb begin
    state_nxt = state;
    rdy_nxt   = frame_ready;
    case (state)
      IDLE:    if (proc) state_nxt = CAPTURE;
      CAPTURE: if (proc && last) begin
                 state_nxt = FULL;
                 rdy_nxt   = 1'b1;
               end
      FULL:    if (frame_ack) begin
                 state_nxt = IDLE;
                 rdy_nxt   = 1'b0;
               end
      default: state_nxt = IDLE;
    endcase
  end

  decim_bank #(.LEN(LEN), .ADR_W(ADR_W)) u_bank (
    .clk(clk), .we(we), .wa(wa), .wd(wd), .ra(rd_adr), .rd(rd_byte)
  );
`endif

endmodule

// File: tb/tb_img_decimator.sv
// Directed bench for img_decimator: frame capture, handshake, resync and reset.
module tb_img_decimator;

  localparam int IN_W  = 128;
  localparam int IN_H  = 128;
  localparam int NPIX  = IN_W*IN_H;
  localparam int ADR_W = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             pix_valid;
  logic             pix_sof;
  logic [7:0]       pix_data;
  logic             pix_ready;
  logic [ADR_W-1:0] rd_adr;
  logic [7:0]       rd_byte;
  logic             frame_ready;
  logic             frame_ack;
  logic             sync_err;

  int         tests = 0;
  int         fails = 0;
  int         bad, fa;
  logic [7:0] got, want, fg, fe;

  always #5 clk = ~clk;

  img_decimator dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .pix_ready(pix_ready), .rd_adr(rd_adr), .rd_byte(rd_byte),
    .frame_ready(frame_ready), .frame_ack(frame_ack), .sync_err(sync_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [7:0] d, input logic sof);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  // idle cycles carry junk data and a stray sof that must be ignored
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b0;
      pix_sof   = 1'b1;
      pix_data  = 8'($urandom);
      tick();
    end
    pix_sof = 1'b0;
  endtask

  task automatic send_range(input bit ramp, input logic [7:0] val,
                            input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      send_pixel(ramp ? 8'(i % IN_W) : val, i == 0);
      if (gaps && $urandom_range(0, 31) == 0) idle_gap($urandom_range(1, 3));
    end
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic read_byte(input int a, output logic [7:0] d);
    rd_adr = ADR_W'(a);
    #1;
    d = rd_byte;
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'h00;
    frame_ack = 1'b0; rd_adr = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tests++; if (frame_ready !== 1'b0) begin fails++; $display("FAIL reset_frame_ready: got %b expected 0", frame_ready); end
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL reset_pix_ready: got %b expected 1", pix_ready); end
    tests++; if (sync_err !== 1'b0) begin fails++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
    read_byte(256, got);
    tests++; if (got !== 8'h00) begin fails++; $display("FAIL reset_oob_read: got %02h expected 00", got); end
  endtask

  task automatic test_const();
    send_range(1'b0, 8'h80, 0, NPIX-2, 1'b0);
    tests++; if (frame_ready !== 1'b0) begin fails++; $display("FAIL const_ready_early: got %b expected 0", frame_ready); end
    send_range(1'b0, 8'h80, NPIX-1, NPIX-1, 1'b0);
    tests++; if (frame_ready !== 1'b1) begin fails++; $display("FAIL const_ready_latency: got %b expected 1", frame_ready); end
`ifndef IMG_DECIMATOR_DOUBLE_BUF_EN
    tests++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL const_full_stall: got %b expected 0", pix_ready); end
`else
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL const_no_stall: got %b expected 1", pix_ready); end
`endif
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      read_byte(a, got);
      want = 8'h80;
      if (got !== want) begin if (bad == 0) begin fa = a; fg = got; fe = want; end bad++; end
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL const_image: %0d bytes wrong, adr %0d got %02h expected %02h", bad, fa, fg, fe); end
    read_byte(256, got);
    tests++; if (got !== 8'h00) begin fails++; $display("FAIL const_oob_256: got %02h expected 00", got); end
    read_byte(511, got);
    tests++; if (got !== 8'h00) begin fails++; $display("FAIL const_oob_511: got %02h expected 00", got); end
  endtask

  task automatic test_backpressure();
    pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 8'h00;
    repeat (4) tick();
    tests++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL bp_pix_ready: got %b expected 0", pix_ready); end
    tests++; if (frame_ready !== 1'b1) begin fails++; $display("FAIL bp_frame_ready: got %b expected 1", frame_ready); end
    pix_valid = 1'b0; pix_sof = 1'b0;
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      read_byte(a, got);
      want = 8'h80;
      if (got !== want) begin if (bad == 0) begin fa = a; fg = got; fe = want; end bad++; end
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL bp_image_held: %0d bytes wrong, adr %0d got %02h expected %02h", bad, fa, fg, fe); end
    pulse_ack();
    tests++; if (frame_ready !== 1'b0) begin fails++; $display("FAIL bp_ack_drop: got %b expected 0", frame_ready); end
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL bp_ack_ready: got %b expected 1", pix_ready); end
  endtask

  task automatic test_ramp();
    send_range(1'b1, 8'h00, 0, NPIX-2, 1'b1);
    tests++; if (frame_ready !== 1'b0) begin fails++; $display("FAIL ramp_ready_early: got %b expected 0", frame_ready); end
    send_range(1'b1, 8'h00, NPIX-1, NPIX-1, 1'b1);
    tests++; if (frame_ready !== 1'b1) begin fails++; $display("FAIL ramp_ready: got %b expected 1", frame_ready); end
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      read_byte(a, got);
      want = 8'(8*(a % 16) + 3);
      if (got !== want) begin if (bad == 0) begin fa = a; fg = got; fe = want; end bad++; end
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL ramp_image: %0d bytes wrong, adr %0d got %02h expected %02h", bad, fa, fg, fe); end
  endtask

  task automatic test_sync();
    pulse_ack();
    tests++; if (frame_ready !== 1'b0) begin fails++; $display("FAIL sync_ack_drop: got %b expected 0", frame_ready); end
    send_range(1'b1, 8'h00, 0, 2499, 1'b0);
    pulse_ack();
    send_range(1'b1, 8'h00, 2500, 4999, 1'b0);
    tests++; if (sync_err !== 1'b0) begin fails++; $display("FAIL sync_quiet: got %b expected 0", sync_err); end
    send_pixel(8'h10, 1'b1);
    tests++; if (sync_err !== 1'b1) begin fails++; $display("FAIL sync_pulse: got %b expected 1", sync_err); end
    send_range(1'b0, 8'h10, 1, 1, 1'b0);
    tests++; if (sync_err !== 1'b0) begin fails++; $display("FAIL sync_single: got %b expected 0", sync_err); end
    send_range(1'b0, 8'h10, 2, NPIX-2, 1'b0);
    tests++; if (frame_ready !== 1'b0) begin fails++; $display("FAIL sync_ready_early: got %b expected 0", frame_ready); end
    send_range(1'b0, 8'h10, NPIX-1, NPIX-1, 1'b0);
    tests++; if (frame_ready !== 1'b1) begin fails++; $display("FAIL sync_ready: got %b expected 1", frame_ready); end
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      read_byte(a, got);
      want = 8'h10;
      if (got !== want) begin if (bad == 0) begin fa = a; fg = got; fe = want; end bad++; end
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL sync_image: %0d bytes wrong, adr %0d got %02h expected %02h", bad, fa, fg, fe); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; tick(); reset = 1'b0;
    tests++; if (frame_ready !== 1'b0) begin fails++; $display("FAIL rst_presented_drop: got %b expected 0", frame_ready); end
    send_range(1'b0, 8'h33, 0, 8999, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b expected 1", pix_ready); end
    for (int i = 0; i < 20; i++) send_pixel(8'h00, 1'b0);
    send_pixel(8'hFF, 1'b1);
    tests++; if (sync_err !== 1'b0) begin fails++; $display("FAIL rst_dropped_sof: got %b expected 0", sync_err); end
    send_range(1'b0, 8'hFF, 1, NPIX-2, 1'b0);
    tests++; if (frame_ready !== 1'b0) begin fails++; $display("FAIL rst_ready_early: got %b expected 0", frame_ready); end
    send_range(1'b0, 8'hFF, NPIX-1, NPIX-1, 1'b0);
    tests++; if (frame_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b expected 1", frame_ready); end
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      read_byte(a, got);
      want = 8'hFF;
      if (got !== want) begin if (bad == 0) begin fa = a; fg = got; fe = want; end bad++; end
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rst_image: %0d bytes wrong, adr %0d got %02h expected %02h", bad, fa, fg, fe); end
  endtask

  task automatic test_double_buf();
    pulse_ack();
    tests++; if (frame_ready !== 1'b0) begin fails++; $display("FAIL db_ack_drop: got %b expected 0", frame_ready); end
    send_range(1'b0, 8'h11, 0, NPIX-1, 1'b0);
    tests++; if (frame_ready !== 1'b1) begin fails++; $display("FAIL db_a_ready: got %b expected 1", frame_ready); end
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL db_a_no_stall: got %b expected 1", pix_ready); end
    send_range(1'b0, 8'h22, 0, NPIX-1, 1'b0);
    tests++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL db_b_stall: got %b expected 0", pix_ready); end
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      read_byte(a, got);
      want = 8'h11;
      if (got !== want) begin if (bad == 0) begin fa = a; fg = got; fe = want; end bad++; end
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL db_a_image: %0d bytes wrong, adr %0d got %02h expected %02h", bad, fa, fg, fe); end
    pulse_ack();
    tests++; if (frame_ready !== 1'b1) begin fails++; $display("FAIL db_b_ready: got %b expected 1", frame_ready); end
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL db_b_release: got %b expected 1", pix_ready); end
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      read_byte(a, got);
      want = 8'h22;
      if (got !== want) begin if (bad == 0) begin fa = a; fg = got; fe = want; end bad++; end
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL db_b_image: %0d bytes wrong, adr %0d got %02h expected %02h", bad, fa, fg, fe); end
  endtask

  initial begin
    test_reset();
    test_const();
`ifdef IMG_DECIMATOR_DOUBLE_BUF_EN
    pulse_ack();
    test_ramp();
    test_double_buf();
`else
    test_backpressure();
    test_ramp();
    test_sync();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
